// File: rtl/intseq_pkg.sv
// Shared encodings for the interrupt/reset sequencer: states, entry kinds,
// vector bases and the datapath select codes it drives.
package intseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DUMMY, ST_PUSH_PCH, ST_PUSH_PCL,
        ST_PUSH_P, ST_VEC_LO, ST_VEC_HI, ST_FIN
    } state_e;

    typedef enum logic [1:0] {K_RES, K_NMI, K_BRK, K_IRQ} kind_e;

    localparam logic [15:0] C_VEC_NMI = 16'hFFFA;
    localparam logic [15:0] C_VEC_RES = 16'hFFFC;
    localparam logic [15:0] C_VEC_IRQ = 16'hFFFE;

    // Code 0 of every field is the idle/hold meaning, except P_SRC (0 = load DL).
    localparam logic [1:0] C_DB_OUT_NONE    = 2'd0;
    localparam logic [1:0] C_DB_OUT_PCH     = 2'd1;
    localparam logic [1:0] C_DB_OUT_PCL     = 2'd2;
    localparam logic [1:0] C_DB_OUT_P       = 2'd3;
    localparam logic [1:0] C_PCADDER_HOLD   = 2'd0;
    localparam logic [1:0] C_PCADDER_INC    = 2'd1;
    localparam logic       C_PCL_SRC_ADDER  = 1'b0;
    localparam logic       C_PCL_SRC_DL     = 1'b1;
    localparam logic       C_PCH_SRC_ADDER  = 1'b0;
    localparam logic       C_PCH_SRC_DL     = 1'b1;
    localparam logic [1:0] C_REG_SRC_DB     = 2'd0;
    localparam logic [1:0] C_REG_SRC_ALU    = 2'd1;
    localparam logic [1:0] C_P_SRC_DL       = 2'd0;
    localparam logic [1:0] C_P_SRC_HOLD     = 2'd1;
    localparam logic [1:0] C_P_SRC_OR       = 2'd2;
    localparam logic [1:0] C_P_SRC_ANDN     = 2'd3;
    localparam logic [7:0] C_P_MASK_B       = 8'h10;
    localparam logic [7:0] C_P_MASK_I       = 8'h04;
    localparam logic [2:0] C_ALU_CTRL_ADD   = 3'd0;
    localparam logic [2:0] C_ALU_CTRL_DEC   = 3'd1;
    localparam logic [1:0] C_ALU_SRC_A_A    = 2'd0;
    localparam logic [1:0] C_ALU_SRC_A_S    = 2'd1;
    localparam logic [1:0] C_ALU_SRC_B_DB   = 2'd0;
    localparam logic [1:0] C_ALU_SRC_B_ZERO = 2'd1;
    localparam logic [1:0] C_ABL_SRC_PCL    = 2'd0;
    localparam logic [1:0] C_ABL_SRC_S      = 2'd1;
    localparam logic [1:0] C_ABL_SRC_ALU    = 2'd2;
    localparam logic [1:0] C_ABH_SRC_PCH_WD = 2'd0;
    localparam logic [1:0] C_ABH_SRC_01     = 2'd1;

    typedef struct packed {
        logic [1:0] db_out_src;
        logic       dl_we;
        logic [1:0] pcadder_ctrl;
        logic       pcl_src;
        logic       pch_src;
        logic       pcl_we;
        logic       pch_we;
        logic [1:0] reg_src;
        logic       s_we;
        logic [1:0] p_src;
        logic [7:0] p_mask;
        logic [2:0] alu_ctrl;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] abl_src;
        logic [1:0] abh_src;
        logic       abl_we;
        logic       abh_we;
        logic       mem_we;
    } ctl_t;

    function automatic logic [15:0] vec_base(input kind_e k);
        case (k)
            K_NMI:   return C_VEC_NMI;
            K_RES:   return C_VEC_RES;
            default: return C_VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/intseq_nmi_edge.sv
// NMI falling-edge detector with a sticky pending flag, cleared when the
// sequencer takes an NMI. A new edge in the clear cycle is not lost.
module intseq_nmi_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic nmi_n_i,
    input  logic clr_i,
    output logic pend_o
);

    logic prev_q, pend_q, pend_d;

    assign pend_d = (prev_q & ~nmi_n_i) | (pend_q & ~clr_i);
    assign pend_o = pend_q;

    // prev resets low so an input that is already low never counts as an edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= nmi_n_i;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/intseq.sv
// RES/NMI/IRQ/BRK entry sequencer: owns the datapath bundle for the 7-cycle
// push / vector fetch / PC load sequence while BUSY is high.
module intseq
    import intseq_pkg::*;
(
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        NMI_N,
    input  logic        IRQ_N,
    input  logic        INSTR_END,
    input  logic        BRK_REQ,
    input  logic [8:0]  FLAG,
    output logic        TAKE,
    output logic        BUSY,
    output logic        DONE,
    output logic        MEM_WE,
    output logic        VADDR_EN,
    output logic [15:0] VADDR,
    output logic [1:0]  DB_OUT_SRC,
    output logic        DL_WE,
    output logic [1:0]  PCADDER_CTRL,
    output logic        PCL_SRC,
    output logic        PCH_SRC,
    output logic        PCL_WE,
    output logic        PCH_WE,
    output logic [1:0]  REG_SRC,
    output logic        S_WE,
    output logic [1:0]  P_SRC,
    output logic [7:0]  P_MASK,
    output logic [2:0]  ALU_CTRL,
    output logic [1:0]  ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic [1:0]  ABL_SRC,
    output logic [1:0]  ABH_SRC,
    output logic        ABL_WE,
    output logic        ABH_WE
);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic        inc_q, inc_d;
    logic        busy_q, done_q;
    logic        vaddr_en_q, vaddr_en_d;
    logic [15:0] vaddr_q, vaddr_d;
    logic        nmi_pend, irq_req, start, take, push;
    ctl_t        ctl;
    logic        unused_flag;

    assign unused_flag = ^{FLAG[8:3], FLAG[1:0]};
    assign irq_req     = ~IRQ_N & ~FLAG[2];
    assign start       = BRK_REQ | (INSTR_END & (nmi_pend | irq_req));

    intseq_nmi_edge u_nmi_edge (
        .clk_i   (CLK),
        .rst_ni  (RES_N),
        .nmi_n_i (NMI_N),
        .clr_i   (take & nmi_pend),
        .pend_o  (nmi_pend)
    );

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        inc_d      = inc_q;
        vaddr_d    = vaddr_q;
        vaddr_en_d = vaddr_en_q;
        take       = 1'b0;
        push       = 1'b0;
        ctl        = '0;
        ctl.p_src  = C_P_SRC_HOLD;
        // Holding reset suppresses every write, including the one in flight.
        if (RES_N) begin
            case (state_q)
                ST_IDLE: if (start) begin
                    take    = 1'b1;
                    state_d = ST_DUMMY;
                    kind_d  = nmi_pend ? K_NMI : (BRK_REQ ? K_BRK : K_IRQ);
                    inc_d   = BRK_REQ;
                end
                ST_DUMMY: begin
                    state_d     = ST_PUSH_PCH;
                    ctl.abl_src = C_ABL_SRC_S;
                    ctl.abh_src = C_ABH_SRC_01;
                    ctl.abl_we  = 1'b1;
                    ctl.abh_we  = 1'b1;
                    // a BRK displaced by NMI still steps past its padding byte
                    if (inc_q) begin
                        ctl.pcadder_ctrl = C_PCADDER_INC;
                        ctl.pcl_we       = 1'b1;
                        ctl.pch_we       = 1'b1;
                    end
                    ctl.p_mask = C_P_MASK_B;
                    if (kind_q == K_BRK)      ctl.p_src = C_P_SRC_OR;
                    else if (kind_q != K_RES) ctl.p_src = C_P_SRC_ANDN;
                end
                ST_PUSH_PCH: begin
                    state_d        = ST_PUSH_PCL;
                    push           = 1'b1;
                    ctl.db_out_src = C_DB_OUT_PCH;
                    ctl.abl_src    = C_ABL_SRC_ALU;
                    ctl.abl_we     = 1'b1;
                end
                ST_PUSH_PCL: begin
                    state_d        = ST_PUSH_P;
                    push           = 1'b1;
                    ctl.db_out_src = C_DB_OUT_PCL;
                    ctl.abl_src    = C_ABL_SRC_ALU;
                    ctl.abl_we     = 1'b1;
                end
                ST_PUSH_P: begin
                    state_d        = ST_VEC_LO;
                    push           = 1'b1;
                    ctl.db_out_src = C_DB_OUT_P;
                    vaddr_d        = vec_base(kind_q);
                    vaddr_en_d     = 1'b1;
                end
                ST_VEC_LO: begin
                    state_d    = ST_VEC_HI;
                    ctl.dl_we  = 1'b1;
                    ctl.p_src  = C_P_SRC_OR;
                    ctl.p_mask = C_P_MASK_I;
                    vaddr_d    = vaddr_q + 16'd1;
                end
                ST_VEC_HI: begin
                    state_d     = ST_FIN;
                    ctl.pcl_src = C_PCL_SRC_DL;
                    ctl.pcl_we  = 1'b1;
                    ctl.dl_we   = 1'b1;
                    vaddr_en_d  = 1'b0;
                end
                ST_FIN: begin
                    state_d     = ST_IDLE;
                    ctl.pch_src = C_PCH_SRC_DL;
                    ctl.pch_we  = 1'b1;
                    ctl.abh_src = C_ABH_SRC_PCH_WD;
                    ctl.abl_src = C_ABL_SRC_PCL;
                    ctl.abh_we  = 1'b1;
                    ctl.abl_we  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            if (push) begin
                ctl.mem_we    = (kind_q != K_RES);
                ctl.alu_src_a = C_ALU_SRC_A_S;
                ctl.alu_src_b = C_ALU_SRC_B_ZERO;
                ctl.alu_ctrl  = C_ALU_CTRL_DEC;
                ctl.reg_src   = C_REG_SRC_ALU;
                ctl.s_we      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            state_q    <= ST_DUMMY;
            kind_q     <= K_RES;
            inc_q      <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            vaddr_en_q <= 1'b0;
            vaddr_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            inc_q      <= inc_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_FIN);
            vaddr_en_q <= vaddr_en_d;
            vaddr_q    <= vaddr_d;
        end
    end

    assign TAKE         = take;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign VADDR_EN     = vaddr_en_q;
    assign VADDR        = vaddr_q;
    assign MEM_WE       = ctl.mem_we;
    assign DB_OUT_SRC   = ctl.db_out_src;
    assign DL_WE        = ctl.dl_we;
    assign PCADDER_CTRL = ctl.pcadder_ctrl;
    assign PCL_SRC      = ctl.pcl_src;
    assign PCH_SRC      = ctl.pch_src;
    assign PCL_WE       = ctl.pcl_we;
    assign PCH_WE       = ctl.pch_we;
    assign REG_SRC      = ctl.reg_src;
    assign S_WE         = ctl.s_we;
    assign P_SRC        = ctl.p_src;
    assign P_MASK       = ctl.p_mask;
    assign ALU_CTRL     = ctl.alu_ctrl;
    assign ALU_SRC_A    = ctl.alu_src_a;
    assign ALU_SRC_B    = ctl.alu_src_b;
    assign ABL_SRC      = ctl.abl_src;
    assign ABH_SRC      = ctl.abh_src;
    assign ABL_WE       = ctl.abl_we;
    assign ABH_WE       = ctl.abh_we;

endmodule

// File: tb/tb_intseq.sv
// Bench for intseq: a small 6502-style datapath model executes the control
// bundle; expected stack writes go through a scoreboard queue.
module tb_intseq;
    import intseq_pkg::*;

    logic        CLK = 1'b0;
    logic        RES_N, NMI_N, IRQ_N, INSTR_END, BRK_REQ;
    logic [8:0]  FLAG;
    logic        TAKE, BUSY, DONE, MEM_WE, VADDR_EN;
    logic [15:0] VADDR;
    logic [1:0]  DB_OUT_SRC, PCADDER_CTRL, REG_SRC, P_SRC, ALU_SRC_A, ALU_SRC_B, ABL_SRC, ABH_SRC;
    logic        DL_WE, PCL_SRC, PCH_SRC, PCL_WE, PCH_WE, S_WE, ABL_WE, ABH_WE;
    logic [7:0]  P_MASK;
    logic [2:0]  ALU_CTRL;

    intseq dut (
        .CLK(CLK), .RES_N(RES_N), .NMI_N(NMI_N), .IRQ_N(IRQ_N),
        .INSTR_END(INSTR_END), .BRK_REQ(BRK_REQ), .FLAG(FLAG),
        .TAKE(TAKE), .BUSY(BUSY), .DONE(DONE), .MEM_WE(MEM_WE),
        .VADDR_EN(VADDR_EN), .VADDR(VADDR),
        .DB_OUT_SRC(DB_OUT_SRC), .DL_WE(DL_WE), .PCADDER_CTRL(PCADDER_CTRL),
        .PCL_SRC(PCL_SRC), .PCH_SRC(PCH_SRC), .PCL_WE(PCL_WE), .PCH_WE(PCH_WE),
        .REG_SRC(REG_SRC), .S_WE(S_WE), .P_SRC(P_SRC), .P_MASK(P_MASK),
        .ALU_CTRL(ALU_CTRL), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
        .ABL_SRC(ABL_SRC), .ABH_SRC(ABH_SRC), .ABL_WE(ABL_WE), .ABH_WE(ABH_WE)
    );

    always #5 CLK = ~CLK;

    // datapath model
    logic [15:0] pc;
    logic [7:0]  s, p, dl, abl, abh;
    logic        ld_en = 1'b0;
    logic [15:0] ld_pc;
    logic [7:0]  ld_s, ld_p;
    logic [7:0]  vec [0:5];
    logic [15:0] addr, adder;
    logic [7:0]  rdata, dbus, alu_a, alu_b, alu, pcl_wd, pch_wd;

    assign FLAG   = {1'b0, p};
    assign addr   = VADDR_EN ? VADDR : {abh, abl};
    assign rdata  = (addr >= 16'hFFFA) ? vec[addr - 16'hFFFA] : 8'h00;
    assign dbus   = (DB_OUT_SRC == C_DB_OUT_PCH) ? pc[15:8] :
                    (DB_OUT_SRC == C_DB_OUT_PCL) ? pc[7:0] :
                    (DB_OUT_SRC == C_DB_OUT_P)   ? p : rdata;
    assign adder  = pc + ((PCADDER_CTRL == C_PCADDER_INC) ? 16'd1 : 16'd0);
    assign alu_a  = (ALU_SRC_A == C_ALU_SRC_A_S) ? s : 8'h00;
    assign alu_b  = (ALU_SRC_B == C_ALU_SRC_B_ZERO) ? 8'h00 : dbus;
    assign alu    = (ALU_CTRL == C_ALU_CTRL_DEC) ? alu_a + alu_b - 8'd1 : alu_a + alu_b;
    assign pcl_wd = (PCL_SRC == C_PCL_SRC_DL) ? dl : adder[7:0];
    assign pch_wd = (PCH_SRC == C_PCH_SRC_DL) ? dl : adder[15:8];

    always @(posedge CLK) begin
        if (ld_en) begin
            pc <= ld_pc;
            s  <= ld_s;
            p  <= ld_p;
        end else begin
            if (PCL_WE) pc[7:0]  <= pcl_wd;
            if (PCH_WE) pc[15:8] <= pch_wd;
            if (S_WE)   s <= (REG_SRC == C_REG_SRC_ALU) ? alu : dbus;
            if (DL_WE)  dl <= rdata;
            case (P_SRC)
                C_P_SRC_DL:   p <= dl;
                C_P_SRC_OR:   p <= p | P_MASK;
                C_P_SRC_ANDN: p <= p & ~P_MASK;
                default:      p <= p;
            endcase
            if (ABL_WE) abl <= (ABL_SRC == C_ABL_SRC_S) ? s : (ABL_SRC == C_ABL_SRC_ALU) ? alu : pc[7:0];
            if (ABH_WE) abh <= (ABH_SRC == C_ABH_SRC_01) ? 8'h01 : pch_wd;
        end
    end

    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t sb[$];
    int  checks = 0, errors = 0;

    // write checker: every MEM_WE must match the next expected push
    always @(negedge CLK) begin
        wr_t w;
        #2;
        if (MEM_WE) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h@%h, required no write", dbus, addr);
            end else begin
                w = sb.pop_front();
                if (addr !== w.a || dbus !== w.d) begin
                    errors++;
                    $display("FAIL push: got %h@%h, required %h@%h", dbus, addr, w.d, w.a);
                end
            end
        end
    end

    task automatic load(input logic [15:0] v_pc, input logic [7:0] v_s, input logic [7:0] v_p);
        ld_pc = v_pc; ld_s = v_s; ld_p = v_p; ld_en = 1'b1;
        @(negedge CLK);
        ld_en = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        sb.push_back('{a: a, d: d});
    endtask

    task automatic test_reset();
        int n;
        RES_N = 1'b0;
        load(16'h0000, 8'hFF, 8'h00);
        @(negedge CLK);
        checks++;
        if ({BUSY, DONE, VADDR_EN, VADDR, TAKE, MEM_WE} !== {3'b100, 16'h0000, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b ven=%b vaddr=%h take=%b we=%b, required 1 0 0 0000 0 0",
                     BUSY, DONE, VADDR_EN, VADDR, TAKE, MEM_WE);
        end
        RES_N = 1'b1;
        // release cycle is the DUMMY cycle itself, so DONE shows 6 samples later
        n = 0;
        while (!DONE && n < 20) begin @(negedge CLK); n++; end
        checks++;
        if (n !== 6) begin errors++; $display("FAIL reset_latency: got %0d, required 6", n); end
        @(posedge CLK); #1;
        checks++;
        if (pc !== 16'h1234 || s !== 8'hFC || p[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_result: got pc=%h s=%h i=%b, required 1234 fc 1", pc, s, p[2]);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL reset_idle: got busy=%b pending=%0d, required 0 0", BUSY, sb.size());
        end
    endtask

    task automatic test_irq();
        int n;
        load(16'h8000, 8'hFF, 8'h11);
        push_exp(16'h01FF, 8'h80); push_exp(16'h01FE, 8'h00); push_exp(16'h01FD, 8'h01);
        IRQ_N = 1'b0; INSTR_END = 1'b1; #1;
        checks++;
        if (TAKE !== 1'b1) begin errors++; $display("FAIL irq_take: got %b, required 1", TAKE); end
        @(negedge CLK);
        INSTR_END = 1'b0; IRQ_N = 1'b1;
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL irq_busy: got %b, required 1", BUSY); end
        n = 1;
        while (!DONE && n < 20) begin
            @(negedge CLK); n++;
            if (n == 5) begin
                checks++;
                if (VADDR_EN !== 1'b1 || VADDR !== 16'hFFFE) begin
                    errors++; $display("FAIL irq_vector: got en=%b %h, required 1 fffe", VADDR_EN, VADDR);
                end
            end
        end
        checks++;
        if (n !== 7) begin errors++; $display("FAIL irq_latency: got %0d, required 7", n); end
        @(posedge CLK); #1;
        checks++;
        if (pc !== 16'hABCD || s !== 8'hFC || p !== 8'h05) begin
            errors++; $display("FAIL irq_result: got pc=%h s=%h p=%h, required abcd fc 05", pc, s, p);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL irq_idle: got busy=%b pending=%0d, required 0 0", BUSY, sb.size());
        end
    endtask

    task automatic test_masked_irq();
        IRQ_N = 1'b0; INSTR_END = 1'b1; #1;
        checks++;
        if (TAKE !== 1'b0) begin errors++; $display("FAIL masked_take: got %b, required 0", TAKE); end
        @(negedge CLK);
        INSTR_END = 1'b0; IRQ_N = 1'b1;
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL masked_busy: got %b, required 0", BUSY); end
    endtask

    task automatic test_brk_nmi();
        int n;
        load(16'h9001, 8'hFF, 8'h04);
        push_exp(16'h01FF, 8'h90); push_exp(16'h01FE, 8'h02); push_exp(16'h01FD, 8'h14);
        BRK_REQ = 1'b1; #1;
        checks++;
        if (TAKE !== 1'b1) begin errors++; $display("FAIL brk_take: got %b, required 1", TAKE); end
        @(negedge CLK);
        BRK_REQ = 1'b0;
        n = 1;
        while (!DONE && n < 20) begin
            @(negedge CLK); n++;
            if (n == 3) NMI_N = 1'b0;
            if (n == 6) begin
                checks++;
                if (VADDR_EN !== 1'b1 || VADDR !== 16'hFFFF) begin
                    errors++; $display("FAIL brk_vector: got en=%b %h, required 1 ffff", VADDR_EN, VADDR);
                end
            end
        end
        checks++;
        if (n !== 7) begin errors++; $display("FAIL brk_latency: got %0d, required 7", n); end
        @(posedge CLK); #1;
        checks++;
        if (pc !== 16'hABCD || s !== 8'hFC || p !== 8'h14) begin
            errors++; $display("FAIL brk_result: got pc=%h s=%h p=%h, required abcd fc 14", pc, s, p);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            checks++;
            if (BUSY !== 1'b0 || TAKE !== 1'b0) begin
                errors++; $display("FAIL nmi_deferred: got busy=%b take=%b, required 0 0", BUSY, TAKE);
            end
        end
        push_exp(16'h01FC, 8'hAB); push_exp(16'h01FB, 8'hCD); push_exp(16'h01FA, 8'h04);
        INSTR_END = 1'b1; #1;
        checks++;
        if (TAKE !== 1'b1) begin errors++; $display("FAIL nmi_take: got %b, required 1", TAKE); end
        @(negedge CLK);
        INSTR_END = 1'b0;
        n = 1;
        while (!DONE && n < 20) begin
            @(negedge CLK); n++;
            if (n == 5) begin
                checks++;
                if (VADDR !== 16'hFFFA) begin errors++; $display("FAIL nmi_vector: got %h, required fffa", VADDR); end
            end
        end
        @(posedge CLK); #1;
        checks++;
        if (pc !== 16'h5678 || s !== 8'hF9) begin
            errors++; $display("FAIL nmi_result: got pc=%h s=%h, required 5678 f9", pc, s);
        end
        @(negedge CLK);
        INSTR_END = 1'b1; #1;
        checks++;
        if (TAKE !== 1'b0) begin errors++; $display("FAIL nmi_retrigger: got %b, required 0", TAKE); end
        @(negedge CLK);
        INSTR_END = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL nmi_idle: got busy=%b pending=%0d, required 0 0", BUSY, sb.size());
        end
        NMI_N = 1'b1;
    endtask

    task automatic test_abort();
        int n;
        load(16'h4000, 8'hFF, 8'h00);
        push_exp(16'h01FF, 8'h40);
        IRQ_N = 1'b0; INSTR_END = 1'b1; #1;
        checks++;
        if (TAKE !== 1'b1) begin errors++; $display("FAIL abort_take: got %b, required 1", TAKE); end
        @(negedge CLK);
        INSTR_END = 1'b0; IRQ_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RES_N = 1'b0; #1;
        checks++;
        if (MEM_WE !== 1'b0) begin errors++; $display("FAIL abort_we: got %b, required 0", MEM_WE); end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            errors++; $display("FAIL abort_hold: got busy=%b done=%b, required 1 0", BUSY, DONE);
        end
        RES_N = 1'b1;
        n = 0;
        while (!DONE && n < 20) begin @(negedge CLK); n++; end
        @(posedge CLK); #1;
        checks++;
        if (n !== 6 || pc !== 16'h1234 || p[2] !== 1'b1) begin
            errors++; $display("FAIL abort_res: got lat=%0d pc=%h i=%b, required 6 1234 1", n, pc, p[2]);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL abort_idle: got busy=%b pending=%0d, required 0 0", BUSY, sb.size());
        end
    endtask

    initial begin
        NMI_N = 1'b1; IRQ_N = 1'b1; INSTR_END = 1'b0; BRK_REQ = 1'b0; RES_N = 1'b0;
        vec[0] = 8'h78; vec[1] = 8'h56; vec[2] = 8'h34;
        vec[3] = 8'h12; vec[4] = 8'hCD; vec[5] = 8'hAB;
        @(negedge CLK);
        test_reset();
        test_irq();
        test_masked_irq();
        test_brk_nmi();
        test_abort();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intseq.md
# intseq

Interrupt/reset sequencer for the mc6502 core. It owns the datapath during the 7-cycle RES/NMI/IRQ/BRK entry sequence. It detects and prioritises interrupt requests, takes over the datapath control bundle from the main instruction controller at instruction boundaries, and performs three things in order: the stack pushes, the vector fetch and the PC load. It sits beside the main controller; the top level selects this block's control bundle whenever `BUSY` is high.

## Interface
No parameters.
- `CLK` in 1: core clock.
- `RES_N` in 1: one clock; reset is synchronous and active-low.
- `NMI_N` in 1: NMI request, falling-edge sensitive.
- `IRQ_N` in 1: IRQ request, level sensitive.
- `INSTR_END` in 1: main controller's last cycle of an instruction (1-cycle pulse).
- `BRK_REQ` in 1: main controller decoded BRK; PC already points at the padding byte.
- `FLAG` in 9: datapath flags; bit 2 = I.
- `TAKE` out 1: combinational; sequence starts next cycle, so the main controller must suppress its opcode fetch.
- `BUSY` out 1: registered; this block drives the datapath bundle.
- `DONE` out 1: registered 1-cycle pulse in the last sequence cycle.
- `MEM_WE` out 1: memory write strobe.
- `VADDR_EN` out 1: registered; when high, the top level drives the address bus from `VADDR` instead of ABH/ABL.
- `VADDR` out 16: vector address.
- Datapath bundle out, widths per datapath: `DB_OUT_SRC`, `DL_WE`, `PCADDER_CTRL`, `PCL_SRC`, `PCH_SRC`, `PCL_WE`, `PCH_WE`, `REG_SRC`, `S_WE`, `P_SRC`, `P_MASK`, `ALU_CTRL`, `ALU_SRC_A`, `ALU_SRC_B`, `ABL_SRC`, `ABH_SRC`, `ABL_WE`, `ABH_WE`.

## Operation
- States: IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, FIN. The register `kind` ∈ {RES, NMI, BRK, IRQ}.
- Pending logic:
  - `nmi_pend` is set when `NMI_N` sampled 1 then 0. It is cleared when an NMI sequence is taken.
  - `irq_req` = ~IRQ_N & ~FLAG[2], evaluated at the boundary.
- Start condition: only in IDLE, on `INSTR_END` or `BRK_REQ`. Priority NMI > BRK > IRQ. `TAKE` = IDLE & (BRK_REQ | INSTR_END&(nmi_pend|irq_req)).
- Defaults, in IDLE and for any field not named below:
  - all WE = 0, `MEM_WE` = 0.
  - `P_SRC` = C_P_SRC_HOLD. Code 0 loads DL, so it is never a default.
  - `PCADDER_CTRL` = hold.
- DUMMY:
  - load AB = {01, S}: ABL_SRC = C_ABL_SRC_S, ABH_SRC = C_ABH_SRC_01, both WE.
  - BRK only: PCADDER_CTRL = INC, PCL_WE = PCH_WE = 1, sources = adder.
  - BRK sets B (P_SRC = OR, mask 0x10). NMI/IRQ clear B (AND-NOT, mask 0x10).
- PUSH_PCH / PUSH_PCL / PUSH_P:
  - DB_OUT_SRC = pch / pcl / p.
  - MEM_WE = 1, except kind = RES, where MEM_WE = 0 and the cycles are reads.
  - S ← S−1: ALU_SRC_A = s, ALU_SRC_B = zero, ALU_CTRL = C_ALU_CTRL_DEC, REG_SRC = alu_out, S_WE.
  - In PUSH_PCH and PUSH_PCL: ABL ← alu_out, ABL_WE.
  - In PUSH_P: VADDR ← base, VADDR_EN ← 1. Base is FFFA for NMI, FFFC for RES, FFFE for IRQ/BRK.
- VEC_LO: DL_WE (low byte); set I (P_SRC = OR, mask 0x04); VADDR ← base+1.
- VEC_HI: PCL_SRC = dl, PCL_WE; DL_WE (high byte); VADDR_EN ← 0.
- FIN:
  - PCH_SRC = dl, PCH_WE.
  - AB ← {dl, pcl}: ABH_SRC = pch_wd, ABL_SRC = pcl, both WE.
  - DONE = 1; next state IDLE; BUSY ← 0.
- A pending NMI that arrives during a sequence is served at the next `INSTR_END`, i.e. after the handler's first instruction.

## Timing
- Reset values:
  - state = DUMMY, kind = RES, BUSY = 1.
  - DONE = 0, VADDR_EN = 0, VADDR = 0000, nmi_pend = 0.
  - Effect: the RES sequence runs automatically in the 7 cycles after `RES_N` rises.
- `RES_N` low in any state aborts the sequence and restarts RES; no further writes occur.
- Latency: TAKE at cycle n → BUSY at n+1 (DUMMY) → DONE at n+7 (FIN) → main controller fetches at n+8.
- `NMI_N` held low after the edge does not retrigger.
- `BRK_REQ` and `INSTR_END` in the same cycle as a pending NMI take NMI. A BRK displaced this way is not re-executed; the pushed PC is past the padding byte.
- Post-RES S is 3 below its reset value (FF → FC).

## Structure
- The state encoding, `kind` encoding, vector base constants and all datapath select codes go in params.vh. Select codes: C_ABL_SRC_S, C_ABH_SRC_01, C_P_SRC_HOLD/OR/ANDN, C_ALU_CTRL_DEC, C_DB_OUT_PCH/PCL/P, etc.
- One natural sub-module: `nmi_edge` (edge detector plus pending flag, clear input).
- The control decode is a single combinational case on state.

## Test plan
- Reset: RES_N low 2 cycles, mem[FFFC] = 34, [FFFD] = 12 → DONE 7 cycles after release, PC = 1234, S = FC, I = 1, no MEM_WE.
- IRQ: PC = 8000, S = FF, I = 0, IRQ_N = 0, INSTR_END → writes 80@01FF, 00@01FE, P with B = 0 @01FD; vector FFFE; S = FC; I = 1.
- Masked IRQ: I = 1, IRQ_N = 0, INSTR_END → TAKE = 0, BUSY stays 0.
- BRK: BRK_REQ with PC = 9001 → pushes 90, 02, P with B = 1; vector FFFE/FFFF.
- NMI edge during BRK sequence → not taken until DONE plus the next INSTR_END, then vector FFFA. NMI_N held low afterward → no second take.
- RES_N low during PUSH_PCL → no further MEM_WE; RES sequence runs after release, vector FFFC.
